// File: rtl/sys_array_pkg.sv
// Shared types for the systolic-array row feeder.
// Holds the feeder FSM state encoding and a lane-vector type at the default geometry.
package sys_array_pkg;

  localparam int unsigned DEF_DATA_WIDTH = 8;
  localparam int unsigned DEF_ARRAY_L    = 10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FEED  = 2'd1,
    DRAIN = 2'd2
  } feeder_state_e;

  // One matrix row as presented to the array (lane 0 first).
  typedef logic signed [DEF_DATA_WIDTH-1:0] lane_vec_t [0:DEF_ARRAY_L-1];

endpackage

// File: rtl/sys_array_skew_line.sv
// One lane of the skew network: a DEPTH-stage register chain.
// Ports:
//   clk, reset : clock, asynchronous active-high reset (clears every stage)
//   din        : lane input, sampled every cycle
//   dout       : din delayed by DEPTH cycles
module sys_array_skew_line #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DEPTH      = 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic signed [DATA_WIDTH-1:0] din,
  output logic signed [DATA_WIDTH-1:0] dout
);

  logic signed [DATA_WIDTH-1:0] stage_q [0:DEPTH-1];

  // Unconditional shift; zeros enter whenever the feeder is not popping.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) stage_q[i] <= '0;
    end else begin
      stage_q[0] <= din;
      for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign dout = stage_q[DEPTH-1];

endmodule

// File: rtl/sys_array_feeder.sv
// Row FIFO plus diagonal skew feeding a systolic array, one tile at a time.
// Rows are queued with a tile-end marker; a tile is streamed out one row per
// cycle, then ARRAY_L-1 zero cycles flush the skew before the next tile.
// Lane k of a row popped in cycle t appears on out_data[k] in cycle t+1+k.
// A full FIFO with no complete tile queued forces a FIFO_DEPTH-row tile.
// Optional feature macro: SYS_ARRAY_FEEDER_OVF_EN adds the sticky ovf_err output.
// Ports:
//   clk, reset          : clock, asynchronous active-high reset
//   in_valid/in_ready   : row handshake (in_ready = FIFO not full)
//   in_data, in_last    : row lanes and tile-end marker
//   out_data, out_valid : skewed lanes, high while any lane carries tile data
//   busy                : FSM not IDLE
//   done                : one-cycle pulse when a tile has fully left the skew
//   ovf_err             : (macro only) set by a forced start, cleared by reset
module sys_array_feeder
  import sys_array_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ARRAY_L    = 10,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic signed [DATA_WIDTH-1:0] in_data  [0:ARRAY_L-1],
  input  logic                         in_last,
  output logic signed [DATA_WIDTH-1:0] out_data [0:ARRAY_L-1],
  output logic                         out_valid,
  output logic                         busy,
  output logic                         done
`ifdef SYS_ARRAY_FEEDER_OVF_EN
  ,
  output logic                         ovf_err
`endif
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned DRN_W = (ARRAY_L > 1) ? $clog2(ARRAY_L) : 1;

  // FIFO storage and bookkeeping
  logic signed [DATA_WIDTH-1:0] mem_data [0:FIFO_DEPTH-1][0:ARRAY_L-1];
  logic                         mem_last [0:FIFO_DEPTH-1];
  logic [PTR_W-1:0]             wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]             count_q, count_d;
  logic [CNT_W-1:0]             pending_q, pending_d;
  logic                         in_ready_q;
  logic                         push, pop, head_last;

  // FSM
  feeder_state_e                state_q, state_d;
  logic                         forced_q, forced_d;
  logic [PTR_W-1:0]             pop_cnt_q, pop_cnt_d;
  logic [DRN_W-1:0]             drain_cnt_q, drain_cnt_d;
  logic                         done_d, forced_start;
  logic                         valid_q, busy_q, done_q;

  logic signed [DATA_WIDTH-1:0] lane_in [0:ARRAY_L-1];

  assign push      = in_valid && in_ready_q;
  assign head_last = mem_last[rd_ptr_q];
  assign count_d   = count_q + CNT_W'(push) - CNT_W'(pop);
  assign pending_d = pending_q + CNT_W'(push && in_last) - CNT_W'(pop && head_last);

  // Row storage; contents need no reset since pointers gate every read.
  always_ff @(posedge clk) begin
    if (push) begin
      for (int k = 0; k < ARRAY_L; k++) mem_data[wr_ptr_q][k] <= in_data[k];
      mem_last[wr_ptr_q] <= in_last;
    end
  end

  // Pointers, occupancy, queued-tile count and the registered ready flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      pending_q  <= '0;
      in_ready_q <= 1'b1;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q    <= count_d;
      pending_q  <= pending_d;
      in_ready_q <= (count_d != CNT_W'(FIFO_DEPTH));
    end
  end

  // State register and registered status outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      forced_q    <= 1'b0;
      pop_cnt_q   <= '0;
      drain_cnt_q <= '0;
      valid_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      forced_q    <= forced_d;
      pop_cnt_q   <= pop_cnt_d;
      drain_cnt_q <= drain_cnt_d;
      // A lane is live one cycle after any FEED or DRAIN cycle.
      valid_q     <= (state_q != IDLE);
      busy_q      <= (state_d != IDLE);
      done_q      <= done_d;
    end
  end

  // Next-state logic: start on a queued tile (or a full FIFO), pop gap-free, flush.
  always_comb begin
    state_d      = state_q;
    forced_d     = forced_q;
    pop_cnt_d    = pop_cnt_q;
    drain_cnt_d  = drain_cnt_q;
    done_d       = 1'b0;
    pop          = 1'b0;
    forced_start = 1'b0;
    unique case (state_q)
      IDLE: begin
        pop_cnt_d   = '0;
        drain_cnt_d = '0;
        if (pending_q != '0) begin
          state_d  = FEED;
          forced_d = 1'b0;
        end else if (count_q == CNT_W'(FIFO_DEPTH)) begin
          state_d      = FEED;
          forced_d     = 1'b1;
          forced_start = 1'b1;
        end
      end
      FEED: begin
        pop = (count_q != '0);
        if (pop) begin
          pop_cnt_d = pop_cnt_q + PTR_W'(1);
          if (head_last || (forced_q && (pop_cnt_q == PTR_W'(FIFO_DEPTH - 1)))) begin
            state_d     = DRAIN;
            drain_cnt_d = '0;
          end
        end
      end
      DRAIN: begin
        drain_cnt_d = drain_cnt_q + DRN_W'(1);
        if (drain_cnt_q == DRN_W'(ARRAY_L - 2)) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Lane inputs carry the head row only on a pop, zeros otherwise.
  always_comb begin
    for (int k = 0; k < ARRAY_L; k++) begin
      lane_in[k] = '0;
      if (pop) lane_in[k] = mem_data[rd_ptr_q][k];
    end
  end

  for (genvar k = 0; k < ARRAY_L; k++) begin : g_lane
    sys_array_skew_line #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (k + 1)
    ) u_skew (
      .clk   (clk),
      .reset (reset),
      .din   (lane_in[k]),
      .dout  (out_data[k])
    );
  end

`ifdef SYS_ARRAY_FEEDER_OVF_EN
  logic ovf_q;

  // Sticky flag: a forced start means rows arrived without a tile boundary.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)             ovf_q <= 1'b0;
    else if (forced_start) ovf_q <= 1'b1;
  end

  assign ovf_err = ovf_q;
`endif

  assign in_ready  = in_ready_q;
  assign out_valid = valid_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_sys_array_feeder.sv
// Randomized and directed bench for sys_array_feeder against a queue-based reference.
module tb_sys_array_feeder;

  localparam int unsigned DW = 8;
  localparam int unsigned L  = 4;
  localparam int unsigned D  = 16;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 in_valid, in_ready, in_last;
  logic                 out_valid, busy, done;
  logic signed [DW-1:0] in_data  [0:L-1];
  logic signed [DW-1:0] out_data [0:L-1];
`ifdef SYS_ARRAY_FEEDER_OVF_EN
  logic                 ovf_err;
  bit                   m_ovf;
`endif

  sys_array_feeder #(
    .DATA_WIDTH (DW),
    .ARRAY_L    (L),
    .FIFO_DEPTH (D)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_data  (out_data),
    .out_valid (out_valid),
    .busy      (busy),
    .done      (done)
`ifdef SYS_ARRAY_FEEDER_OVF_EN
    ,
    .ovf_err   (ovf_err)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic          last;
    logic [L*DW-1:0] v;
  } row_t;

  // Reference: queue of accepted rows, tile phase, and a record of what was
  // popped in each of the last L cycles (lane k shows the row popped k+1 ago).
  row_t          q[$];
  int            m_pending;
  int            m_mode;       // 0 waiting, 1 streaming rows, 2 flushing
  int            m_left;
  int            m_forced_left;
  bit            m_forced;
  logic [L*DW-1:0] hist [L];
  bit            exp_valid, exp_busy, exp_done, exp_ready;

  int n_cmp = 0;
  int n_err = 0;
  int valid_seen = 0;
  int done_seen  = 0;

  task automatic check(input string tag, input longint obs, input longint exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_pending = 0;
    m_mode    = 0;
    m_left    = 0;
    m_forced  = 1'b0;
    m_forced_left = 0;
    for (int k = 0; k < L; k++) hist[k] = '0;
`ifdef SYS_ARRAY_FEEDER_OVF_EN
    m_ovf = 1'b0;
`endif
  endtask

  task automatic check_zero(input string pfx);
    check({pfx, "_valid"}, out_valid, 0);
    check({pfx, "_busy"},  busy,      0);
    check({pfx, "_done"},  done,      0);
    for (int k = 0; k < L; k++) check($sformatf("%s_lane%0d", pfx, k), out_data[k], 0);
  endtask

  // One clock: advance the reference with the current inputs, then compare at negedge.
  task automatic step();
    row_t pr, r;
    bit   push, popped, dn, act;
    int   nmode;
    logic signed [DW-1:0] e;
    push = in_valid && (q.size() != D);
    r.last = in_last;
    for (int k = 0; k < L; k++) r.v[k*DW +: DW] = in_data[k];
    pr = '0; popped = 1'b0; dn = 1'b0;
    act = (m_mode != 0);
    nmode = m_mode;
    case (m_mode)
      0: begin
        if (m_pending > 0) begin
          nmode = 1; m_forced = 1'b0;
        end else if (q.size() == D) begin
          nmode = 1; m_forced = 1'b1; m_forced_left = D;
`ifdef SYS_ARRAY_FEEDER_OVF_EN
          m_ovf = 1'b1;
`endif
        end
      end
      1: begin
        if (q.size() > 0) begin
          pr = q.pop_front();
          popped = 1'b1;
          if (pr.last) m_pending--;
          if (m_forced) m_forced_left--;
          if (pr.last || (m_forced && m_forced_left == 0)) begin
            nmode = 2; m_left = L - 1;
          end
        end
      end
      default: begin
        m_left--;
        if (m_left == 0) begin nmode = 0; dn = 1'b1; end
      end
    endcase
    if (push) begin
      q.push_back(r);
      if (r.last) m_pending++;
    end
    for (int k = L - 1; k > 0; k--) hist[k] = hist[k-1];
    hist[0] = popped ? pr.v : '0;
    @(posedge clk);
    m_mode    = nmode;
    exp_valid = act;
    exp_busy  = (nmode != 0);
    exp_done  = dn;
    exp_ready = (q.size() != D);
    @(negedge clk);
    check("out_valid", out_valid, exp_valid);
    check("busy",      busy,      exp_busy);
    check("done",      done,      exp_done);
    check("in_ready",  in_ready,  exp_ready);
    for (int k = 0; k < L; k++) begin
      e = hist[k][k*DW +: DW];
      check($sformatf("lane%0d", k), out_data[k], e);
    end
`ifdef SYS_ARRAY_FEEDER_OVF_EN
    check("ovf_err", ovf_err, m_ovf);
`endif
    if (out_valid) valid_seen++;
    if (done)      done_seen++;
  endtask

  task automatic push_row(input int a, input int b, input int c, input int d, input bit last);
    bit acc = 1'b0;
    in_data[0] = DW'(a); in_data[1] = DW'(b); in_data[2] = DW'(c); in_data[3] = DW'(d);
    in_last  = last;
    in_valid = 1'b1;
    for (int n = 0; n < 64 && !acc; n++) begin
      acc = (q.size() != D);
      step();
    end
    check("push_accepted", acc, 1);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_quiet(input string tag);
    int n = 0;
    in_valid = 1'b0;
    in_last  = 1'b0;
    do begin
      step();
      n++;
    end while (!(m_mode == 0 && q.size() == 0) && n < 400);
    check({tag, "_idle"}, busy, 0);
  endtask

  int base_done, base_valid;

  initial begin
    reset    = 1'b1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    for (int k = 0; k < L; k++) in_data[k] = '0;
    model_reset();
    #1;
    check_zero("rst");
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    step();
    check("rst_ready_after", in_ready, 1);

    // Two-row tile.
    base_done = done_seen; base_valid = valid_seen;
    push_row(1, 2, 3, 4, 1'b0);
    push_row(5, 6, 7, 8, 1'b1);
    wait_quiet("s2row");
    check("s2row_done_cnt",  done_seen - base_done, 1);
    check("s2row_valid_cnt", valid_seen - base_valid, 5);

    // Sixteen rows without a tile end force a full-depth tile.
    base_done = done_seen;
    for (int i = 0; i < int'(D); i++) push_row(i + 1, i + 17, i + 33, i + 49, 1'b0);
    check("sforce_ready_full", in_ready, 0);
    wait_quiet("sforce");
    check("sforce_done_cnt", done_seen - base_done, 1);
`ifdef SYS_ARRAY_FEEDER_OVF_EN
    check("sforce_ovf", ovf_err, 1);
`endif

    // Two three-row tiles queued back to back.
    base_done = done_seen; base_valid = valid_seen;
    for (int t = 0; t < 2; t++)
      for (int i = 0; i < 3; i++) push_row(10*t + i + 1, -(i + 1), 50 + i, 100 - i, i == 2);
    wait_quiet("sb2b");
    check("sb2b_done_cnt",  done_seen - base_done, 2);
    check("sb2b_valid_cnt", valid_seen - base_valid, 2 * (3 + int'(L) - 1));

    // Reset in the second row-streaming cycle discards the tile.
    push_row(11, 12, 13, 14, 1'b0);
    push_row(21, 22, 23, 24, 1'b0);
    push_row(31, 32, 33, 34, 1'b1);
    for (int n = 0; n < 20 && m_mode != 1; n++) step();
    step();
    #2 reset = 1'b1;
    #1;
    check_zero("smid_rst");
    model_reset();
    base_done = done_seen;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    step();
    check("smid_ready_after", in_ready, 1);
    repeat (8) step();
    check("smid_no_done", done_seen - base_done, 0);

    // Single-row tile with negative values.
    base_done = done_seen; base_valid = valid_seen;
    push_row(-1, -2, -3, -4, 1'b1);
    wait_quiet("s1row");
    check("s1row_done_cnt",  done_seen - base_done, 1);
    check("s1row_valid_cnt", valid_seen - base_valid, int'(L));

    // Random traffic.
    for (int c = 0; c < 400; c++) begin
      in_valid = 1'($urandom_range(0, 1));
      in_last  = ($urandom_range(0, 4) == 0);
      for (int k = 0; k < L; k++) in_data[k] = DW'($urandom);
      step();
    end
    push_row(7, -7, 7, -7, 1'b1);
    wait_quiet("srand");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
